secuencia_generador: RTL

//   Transmit end for the sequence-detector blocks: serializes a captured bit

---
 rtl/secuencia_generador.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/secuencia_generador.sv
// Serial pattern transmitter: shifts a captured pattern MSB-first onto w with
// per-bit hold time, a repeat count and an idle gap between repeats.
module secuencia_generador #(
  parameter int   WIDTH         = 8,
  parameter int   LEN_W         = 4,
  parameter int   REP_W         = 4,
  parameter int   TICKS_PER_BIT = 1,
  parameter int   GAP_TICKS     = 2,
  parameter logic IDLE_LEVEL    = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  output logic             w,
  output logic             bit_strobe,
  output logic             busy,
  output logic             done
);

  localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   bit_q, bit_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               w_q, w_d;
  logic               strobe_q, strobe_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [REP_W-1:0]   rep_init_s;

  // Clamp requested length to the register width and promote reps=0 to one pass
  always_comb begin
    if (len > LEN_W'(WIDTH)) begin
      len_clamp_s = LEN_W'(WIDTH);
    end else begin
      len_clamp_s = len;
    end
    if (reps == REP_W'(0)) begin
      rep_init_s = REP_W'(1);
    end else begin
      rep_init_s = reps;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    shreg_d  = shreg_q;
    len_d    = len_q;
    bit_d    = bit_q;
    tick_d   = tick_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    w_d      = w_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          pat_d = pattern;
          len_d = len_clamp_s;
          rep_d = rep_init_s;
          if (len_clamp_s == LEN_W'(0)) begin
            done_d = 1'b1;
          end else begin
            state_d  = SEND;
            w_d      = pattern[WIDTH-1];
            shreg_d  = pattern << 1;
            bit_d    = LEN_W'(0);
            tick_d   = TICK_W'(0);
            busy_d   = 1'b1;
            strobe_d = 1'b1;
          end
        end else begin
          w_d    = IDLE_LEVEL;
          busy_d = 1'b0;
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          w_d     = IDLE_LEVEL;
          busy_d  = 1'b0;
        end else if (tick_q == TICK_LAST) begin
          if (bit_q == len_q - LEN_W'(1)) begin
            if (rep_q > REP_W'(1)) begin
              rep_d = rep_q - REP_W'(1);
              if (GAP_TICKS > 0) begin
                state_d = GAP;
                gap_d   = GAP_W'(0);
                w_d     = IDLE_LEVEL;
              end else begin
                w_d      = pat_q[WIDTH-1];
                shreg_d  = pat_q << 1;
                bit_d    = LEN_W'(0);
                tick_d   = TICK_W'(0);
                strobe_d = 1'b1;
              end
            end else begin
              state_d = IDLE;
              w_d     = IDLE_LEVEL;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            w_d      = shreg_q[WIDTH-1];
            shreg_d  = shreg_q << 1;
            bit_d    = bit_q + LEN_W'(1);
            tick_d   = TICK_W'(0);
            strobe_d = 1'b1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          w_d     = IDLE_LEVEL;
          busy_d  = 1'b0;
        end else if (gap_q == GAP_LAST) begin
          state_d  = SEND;
          w_d      = pat_q[WIDTH-1];
          shreg_d  = pat_q << 1;
          bit_d    = LEN_W'(0);
          tick_d   = TICK_W'(0);
          strobe_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        w_d     = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pat_q    <= '0;
      shreg_q  <= '0;
      len_q    <= '0;
      bit_q    <= '0;
      tick_q   <= '0;
      rep_q    <= '0;
      gap_q    <= '0;
      w_q      <= IDLE_LEVEL;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      shreg_q  <= shreg_d;
      len_q    <= len_d;
      bit_q    <= bit_d;
      tick_q   <= tick_d;
      rep_q    <= rep_d;
      gap_q    <= gap_d;
      w_q      <= w_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign w          = w_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
